core_sequencer: RTL and testbench
=================================

CORE_SEQUENCER -- requirements
Module: core_sequencer

Interface
REQ-001 The block SHALL have parameter DATA_W, default 8, meaning the register, ALU and data-memory word width.
REQ-002 The block SHALL have parameter PC_W, default 8, meaning the program-counter and instruction-address width.
REQ-003 The block SHALL have parameter START_PC, default 0, meaning the PC value loaded on each accepted start.
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-006 The block SHALL have port start, input, 1 bit: launches a program run.
REQ-007 The block SHALL have port done, output, 1 bit: the run has reached HALT.
REQ-008 The block SHALL have port busy, output, 1 bit: a run is in progress.
REQ-009 The block SHALL have port ovf, output, 1 bit: sticky arithmetic overflow for the current run.
REQ-010 The block SHALL have port imem_addr, output, PC_W bits: instruction address, equal to the current PC.
REQ-011 The block SHALL have port imem_data, input, 9 bits: instruction word, combinationally valid for imem_addr.
REQ-012 The block SHALL have ports dmem_req (output, 1), dmem_we (output, 1), dmem_addr (output, DATA_W), dmem_wdata (output, DATA_W), dmem_rdata (input, DATA_W) and dmem_ack (input, 1): the data-memory handshake.

Function
REQ-013 Internal state SHALL be four DATA_W registers R0-R3, a PC_W PC, a 9-bit instruction register and FSM states IDLE, FETCH, EXEC, MEM, HALT.
REQ-014 Instruction fields SHALL be op=[8:6], rd=[5:4], rs=[3:2], rt=[1:0], imm4=[3:0].
REQ-015 Opcodes: 000 ADD rd=rs+rt; 001 SUB rd=rs-rt; 010 AND rd=rs&rt; 011 LI rd=zero-extended imm4; 100 LW rd=mem[rs]; 101 SW mem[rs]=rd; 110 BEQZ if rd==0 then PC+=sign-extended imm4, else PC+=1; 111 HALT.
REQ-016 In IDLE or HALT, start=1 SHALL load PC=START_PC, clear R0-R3 and ovf, clear done, and enter FETCH.
REQ-017 start SHALL be ignored while busy=1.
REQ-018 FETCH SHALL latch imem_data into the instruction register and go to EXEC; FETCH SHALL last exactly one cycle.
REQ-019 In EXEC, ADD, SUB, AND and LI SHALL write rd, set PC+=1 and return to FETCH, giving 2 cycles per instruction.
REQ-020 In EXEC, BEQZ SHALL update the PC per REQ-015 and return to FETCH.
REQ-021 In EXEC, LW and SW SHALL go to MEM without changing the PC.
REQ-022 In EXEC, HALT SHALL go to HALT; the PC SHALL hold the HALT address.
REQ-023 In MEM, the block SHALL drive dmem_req=1, dmem_addr=rs, dmem_we=1 for SW / 0 for LW, and dmem_wdata=rd, all held stable until the cycle in which dmem_ack=1.
REQ-024 On the dmem_ack cycle, LW SHALL write dmem_rdata to rd, PC+=1, and the FSM SHALL go to FETCH; dmem_req SHALL be 0 in the following cycle.
REQ-025 Outside MEM, dmem_req and dmem_we SHALL be 0; dmem_ack outside MEM SHALL be ignored.
REQ-026 Arithmetic SHALL wrap modulo 2^DATA_W.
REQ-027 ovf SHALL be set by an ADD carry-out or a SUB borrow, and SHALL stay set until the next accepted start or reset.
REQ-028 PC arithmetic SHALL wrap modulo 2^PC_W; a branch offset of -8..+7 SHALL be relative to the BEQZ address (offset 0 is a self-loop).
REQ-029 busy SHALL be 1 in FETCH, EXEC and MEM; done SHALL be 1 only in HALT.
REQ-030 If rd equals rs or rt, the read SHALL use pre-instruction values.

Reset
REQ-031 reset=1 SHALL take priority over start and over dmem_ack, in every state including mid-MEM.
REQ-032 Reset SHALL put the FSM in IDLE with PC=START_PC, R0-R3=0, instruction register=0, done=0, busy=0, ovf=0, dmem_req=0 and dmem_we=0.

Verification
REQ-033 LI R1,5; LI R2,3; ADD R3,R1,R2; HALT, with start pulsed from IDLE -> R3=8, ovf=0, done=1 at cycle 8 after start, busy=0.
REQ-034 LI R1,15; ADD R1,R1,R1 repeated 5 times at DATA_W=8 -> R1 wraps to 0xE0 and ovf=1 after the 5th ADD; the next start clears ovf.
REQ-035 SW R1 to addr R0 then LW R2, with ack delayed 3 cycles -> dmem_req/addr/wdata stable 4 cycles, R2=R1, PC advances only after ack.
REQ-036 BEQZ R0,-1 at PC=0 -> PC wraps to 255; BEQZ with R1!=0 -> PC+1; offset 0 -> self-loop, busy stays 1.
REQ-037 Assert reset during MEM with ack=1 in the same cycle -> no register write, dmem_req=0 next cycle, IDLE, all outputs at reset values.
REQ-038 Pulse start during a run -> ignored; start in HALT -> restart from START_PC with registers cleared.

Source files
------------

// File: rtl/core_sequencer.sv
// Tiny 4-register load/store sequencer: fetches 9-bit instructions from an
// external instruction memory and executes them until HALT.
module core_sequencer #(
    parameter int unsigned DATA_W   = 8,
    parameter int unsigned PC_W     = 8,
    parameter int unsigned START_PC = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    output logic              done,
    output logic              busy,
    output logic              ovf,
    output logic [PC_W-1:0]   imem_addr,
    input  logic [8:0]        imem_data,
    output logic              dmem_req,
    output logic              dmem_we,
    output logic [DATA_W-1:0] dmem_addr,
    output logic [DATA_W-1:0] dmem_wdata,
    input  logic [DATA_W-1:0] dmem_rdata,
    input  logic              dmem_ack
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FETCH = 3'd1,
        S_EXEC  = 3'd2,
        S_MEM   = 3'd3,
        S_HALT  = 3'd4
    } state_t;

    localparam logic [2:0] OP_ADD  = 3'd0;
    localparam logic [2:0] OP_SUB  = 3'd1;
    localparam logic [2:0] OP_AND  = 3'd2;
    localparam logic [2:0] OP_LI   = 3'd3;
    localparam logic [2:0] OP_LW   = 3'd4;
    localparam logic [2:0] OP_SW   = 3'd5;
    localparam logic [2:0] OP_BEQZ = 3'd6;
    localparam logic [2:0] OP_HALT = 3'd7;

    state_t              state_q, state_d;
    logic [PC_W-1:0]     pc_q, pc_d;
    logic [8:0]          ir_q, ir_d;
    logic [DATA_W-1:0]   regs_q [4];

    logic                clr_regs, wr_en, ovf_d;
    logic [DATA_W-1:0]   wr_val;
    logic                done_d, busy_d, req_d, we_d;
    logic [DATA_W-1:0]   addr_d, wdata_d;

    // Instruction decode and operand reads (pre-instruction register values).
    logic [2:0]          op;
    logic [1:0]          rd;
    logic [3:0]          imm;
    logic [DATA_W-1:0]   rd_v, rs_v, rt_v;
    logic [DATA_W:0]     sum_ext;
    logic [PC_W-1:0]     pc_inc, br_off;

    assign op      = ir_q[8:6];
    assign rd      = ir_q[5:4];
    assign imm     = ir_q[3:0];
    assign rd_v    = regs_q[rd];
    assign rs_v    = regs_q[ir_q[3:2]];
    assign rt_v    = regs_q[ir_q[1:0]];
    assign sum_ext = {1'b0, rs_v} + {1'b0, rt_v};
    assign pc_inc  = pc_q + PC_W'(1);
    assign br_off  = {{(PC_W-4){imm[3]}}, imm};

    assign imem_addr = pc_q;

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE, S_HALT: if (start) state_d = S_FETCH;
            S_FETCH:        state_d = S_EXEC;
            S_EXEC: begin
                if (op == OP_LW || op == OP_SW) state_d = S_MEM;
                else if (op == OP_HALT)         state_d = S_HALT;
                else                            state_d = S_FETCH;
            end
            S_MEM:          if (dmem_ack) state_d = S_FETCH;
            default:        state_d = S_IDLE;
        endcase
    end

    // Datapath and next-output logic
    always_comb begin
        pc_d     = pc_q;
        ir_d     = ir_q;
        ovf_d    = ovf;
        clr_regs = 1'b0;
        wr_en    = 1'b0;
        wr_val   = '0;
        unique case (state_q)
            S_IDLE, S_HALT: begin
                if (start) begin
                    pc_d     = PC_W'(START_PC);
                    clr_regs = 1'b1;
                    ovf_d    = 1'b0;
                end
            end
            S_FETCH: ir_d = imem_data;
            S_EXEC: begin
                unique case (op)
                    OP_ADD: begin
                        wr_en  = 1'b1;
                        wr_val = sum_ext[DATA_W-1:0];
                        ovf_d  = ovf | sum_ext[DATA_W];
                        pc_d   = pc_inc;
                    end
                    OP_SUB: begin
                        wr_en  = 1'b1;
                        wr_val = rs_v - rt_v;
                        ovf_d  = ovf | (rs_v < rt_v);
                        pc_d   = pc_inc;
                    end
                    OP_AND: begin
                        wr_en  = 1'b1;
                        wr_val = rs_v & rt_v;
                        pc_d   = pc_inc;
                    end
                    OP_LI: begin
                        wr_en  = 1'b1;
                        wr_val = DATA_W'(imm);
                        pc_d   = pc_inc;
                    end
                    OP_BEQZ: pc_d = (rd_v == '0) ? (pc_q + br_off) : pc_inc;
                    default: ;
                endcase
            end
            S_MEM: begin
                if (dmem_ack) begin
                    wr_en  = (op == OP_LW);
                    wr_val = dmem_rdata;
                    pc_d   = pc_inc;
                end
            end
            default: ;
        endcase

        done_d  = (state_d == S_HALT);
        busy_d  = (state_d == S_FETCH) || (state_d == S_EXEC) || (state_d == S_MEM);
        req_d   = (state_d == S_MEM);
        we_d    = req_d && (op == OP_SW);
        addr_d  = req_d ? rs_v : '0;
        wdata_d = req_d ? rd_v : '0;
    end

    // Datapath and registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q       <= PC_W'(START_PC);
            ir_q       <= '0;
            ovf        <= 1'b0;
            done       <= 1'b0;
            busy       <= 1'b0;
            dmem_req   <= 1'b0;
            dmem_we    <= 1'b0;
            dmem_addr  <= '0;
            dmem_wdata <= '0;
            for (int i = 0; i < 4; i++) regs_q[i] <= '0;
        end else begin
            pc_q       <= pc_d;
            ir_q       <= ir_d;
            ovf        <= ovf_d;
            done       <= done_d;
            busy       <= busy_d;
            dmem_req   <= req_d;
            dmem_we    <= we_d;
            dmem_addr  <= addr_d;
            dmem_wdata <= wdata_d;
            for (int i = 0; i < 4; i++) begin
                if (clr_regs)                      regs_q[i] <= '0;
                else if (wr_en && rd == 2'(i))     regs_q[i] <= wr_val;
            end
        end
    end

endmodule

// File: tb/tb_core_sequencer.sv
// Directed self-checking bench for core_sequencer (DATA_W=8, PC_W=8, START_PC=0).
module tb_core_sequencer;

    logic       clk = 1'b0;
    logic       reset, start;
    logic       done, busy, ovf;
    logic [7:0] imem_addr;
    logic [8:0] imem_data;
    logic       dmem_req, dmem_we;
    logic [7:0] dmem_addr, dmem_wdata, dmem_rdata;
    logic       dmem_ack;

    logic [8:0] imem [256];
    int checks = 0;
    int errors = 0;

    localparam logic [2:0] ADD = 3'd0, SUB = 3'd1, AND_ = 3'd2, LI = 3'd3;
    localparam logic [2:0] LW = 3'd4, SW = 3'd5, BEQZ = 3'd6, HALT = 3'd7;

    assign imem_data = imem[imem_addr];

    always #5 clk = ~clk;

    core_sequencer #(.DATA_W(8), .PC_W(8), .START_PC(0)) dut (
        .clk(clk), .reset(reset), .start(start), .done(done), .busy(busy), .ovf(ovf),
        .imem_addr(imem_addr), .imem_data(imem_data),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
        .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack)
    );

    function automatic logic [8:0] enc_r(input logic [2:0] op, input logic [1:0] rd,
                                         input logic [1:0] rs, input logic [1:0] rt);
        return {op, rd, rs, rt};
    endfunction

    function automatic logic [8:0] enc_i(input logic [2:0] op, input logic [1:0] rd,
                                         input logic [3:0] imm);
        return {op, rd, imm};
    endfunction

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step(2);
        reset = 1'b0;
        for (int i = 0; i < 256; i++) imem[i] = {HALT, 6'd0};
    endtask

    task automatic pulse_start();
        start = 1'b1;
        step(1);
        start = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %0d exp 0", done); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %0d exp 0", busy); end
        checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL reset_ovf: got %0d exp 0", ovf); end
        checks++; if (dmem_req !== 1'b0 || dmem_we !== 1'b0) begin errors++; $display("FAIL reset_dmem: req %0d we %0d exp 0 0", dmem_req, dmem_we); end
        checks++; if (imem_addr !== 8'd0) begin errors++; $display("FAIL reset_pc: got %0d exp 0", imem_addr); end
    endtask

    task automatic test_add_prog();
        do_reset();
        imem[0] = enc_i(LI, 2'd1, 4'd5);
        imem[1] = enc_i(LI, 2'd2, 4'd3);
        imem[2] = enc_r(ADD, 2'd3, 2'd1, 2'd2);
        imem[3] = {HALT, 6'd0};
        pulse_start();
        step(7);
        checks++; if (done !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL add_cycle7: done %0d busy %0d exp 0 1", done, busy); end
        step(1);
        checks++; if (done !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL add_cycle8: done %0d busy %0d exp 1 0", done, busy); end
        checks++; if (dut.regs_q[3] !== 8'd8) begin errors++; $display("FAIL add_r3: got %0d exp 8", dut.regs_q[3]); end
        checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL add_ovf: got %0d exp 0", ovf); end
        checks++; if (imem_addr !== 8'd3) begin errors++; $display("FAIL add_halt_pc: got %0d exp 3", imem_addr); end
    endtask

    task automatic test_overflow();
        do_reset();
        imem[0] = enc_i(LI, 2'd1, 4'd15);
        for (int i = 1; i <= 5; i++) imem[i] = enc_r(ADD, 2'd1, 2'd1, 2'd1);
        pulse_start();
        step(10);
        checks++; if (dut.regs_q[1] !== 8'd240 || ovf !== 1'b0) begin errors++; $display("FAIL ovf_add4: r1 %0d ovf %0d exp 240 0", dut.regs_q[1], ovf); end
        step(2);
        checks++; if (dut.regs_q[1] !== 8'hE0 || ovf !== 1'b1) begin errors++; $display("FAIL ovf_add5: r1 %0h ovf %0d exp e0 1", dut.regs_q[1], ovf); end
        step(2);
        checks++; if (done !== 1'b1 || ovf !== 1'b1) begin errors++; $display("FAIL ovf_sticky: done %0d ovf %0d exp 1 1", done, ovf); end
        pulse_start();
        checks++; if (ovf !== 1'b0 || dut.regs_q[1] !== 8'd0 || busy !== 1'b1 || done !== 1'b0) begin
            errors++; $display("FAIL ovf_restart: ovf %0d r1 %0d busy %0d done %0d exp 0 0 1 0", ovf, dut.regs_q[1], busy, done); end
    endtask

    task automatic test_sub_and();
        do_reset();
        imem[0] = enc_i(LI, 2'd1, 4'd3);
        imem[1] = enc_r(SUB, 2'd2, 2'd0, 2'd1);
        imem[2] = enc_r(AND_, 2'd3, 2'd2, 2'd1);
        pulse_start();
        step(2);
        checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL sub_pre_ovf: got %0d exp 0", ovf); end
        step(2);
        checks++; if (dut.regs_q[2] !== 8'hFD || ovf !== 1'b1) begin errors++; $display("FAIL sub_borrow: r2 %0h ovf %0d exp fd 1", dut.regs_q[2], ovf); end
        step(2);
        checks++; if (dut.regs_q[3] !== 8'd1) begin errors++; $display("FAIL and_r3: got %0d exp 1", dut.regs_q[3]); end
    endtask

    task automatic test_mem();
        do_reset();
        imem[0] = enc_i(LI, 2'd1, 4'd9);
        imem[1] = enc_r(SW, 2'd1, 2'd0, 2'd0);
        imem[2] = enc_r(LW, 2'd2, 2'd0, 2'd0);
        pulse_start();
        step(4);
        for (int c = 0; c < 4; c++) begin
            checks++; if (dmem_req !== 1'b1 || dmem_we !== 1'b1 || dmem_addr !== 8'd0 || dmem_wdata !== 8'd9 || imem_addr !== 8'd1) begin
                errors++; $display("FAIL sw_hold%0d: req %0d we %0d addr %0d wdata %0d pc %0d exp 1 1 0 9 1", c, dmem_req, dmem_we, dmem_addr, dmem_wdata, imem_addr); end
            if (c == 3) dmem_ack = 1'b1;
            step(1);
        end
        dmem_ack = 1'b0;
        checks++; if (dmem_req !== 1'b0 || dmem_we !== 1'b0 || imem_addr !== 8'd2) begin
            errors++; $display("FAIL sw_after_ack: req %0d we %0d pc %0d exp 0 0 2", dmem_req, dmem_we, imem_addr); end
        step(2);
        checks++; if (dmem_req !== 1'b1 || dmem_we !== 1'b0 || dmem_addr !== 8'd0 || imem_addr !== 8'd2) begin
            errors++; $display("FAIL lw_req: req %0d we %0d addr %0d pc %0d exp 1 0 0 2", dmem_req, dmem_we, dmem_addr, imem_addr); end
        dmem_ack = 1'b1;
        dmem_rdata = 8'd9;
        step(1);
        dmem_ack = 1'b0;
        checks++; if (dmem_req !== 1'b0 || imem_addr !== 8'd3 || dut.regs_q[2] !== 8'd9) begin
            errors++; $display("FAIL lw_done: req %0d pc %0d r2 %0d exp 0 3 9", dmem_req, imem_addr, dut.regs_q[2]); end
        step(2);
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL mem_halt: done %0d exp 1", done); end
    endtask

    task automatic test_branch();
        do_reset();
        imem[0] = enc_i(BEQZ, 2'd0, 4'hF);
        pulse_start();
        step(2);
        checks++; if (imem_addr !== 8'd255 || busy !== 1'b1) begin errors++; $display("FAIL beqz_wrap: pc %0d busy %0d exp 255 1", imem_addr, busy); end
        do_reset();
        imem[0] = enc_i(LI, 2'd1, 4'd2);
        imem[1] = enc_i(BEQZ, 2'd1, 4'd5);
        imem[2] = enc_i(BEQZ, 2'd0, 4'd3);
        imem[5] = enc_i(BEQZ, 2'd0, 4'd0);
        pulse_start();
        step(4);
        checks++; if (imem_addr !== 8'd2) begin errors++; $display("FAIL beqz_not_taken: pc %0d exp 2", imem_addr); end
        step(2);
        checks++; if (imem_addr !== 8'd5) begin errors++; $display("FAIL beqz_fwd: pc %0d exp 5", imem_addr); end
        step(4);
        checks++; if (imem_addr !== 8'd5 || busy !== 1'b1 || done !== 1'b0) begin
            errors++; $display("FAIL beqz_self: pc %0d busy %0d done %0d exp 5 1 0", imem_addr, busy, done); end
    endtask

    task automatic test_reset_mid_mem();
        do_reset();
        imem[0] = enc_i(LI, 2'd1, 4'd7);
        imem[1] = enc_r(LW, 2'd1, 2'd0, 2'd0);
        pulse_start();
        step(4);
        checks++; if (dmem_req !== 1'b1) begin errors++; $display("FAIL rmem_req: got %0d exp 1", dmem_req); end
        reset = 1'b1;
        dmem_ack = 1'b1;
        dmem_rdata = 8'hAA;
        step(1);
        checks++; if (dmem_req !== 1'b0 || dmem_we !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || ovf !== 1'b0 || imem_addr !== 8'd0) begin
            errors++; $display("FAIL rmem_outputs: req %0d we %0d busy %0d done %0d ovf %0d pc %0d exp all 0", dmem_req, dmem_we, busy, done, ovf, imem_addr); end
        checks++; if (dut.regs_q[1] !== 8'd0) begin errors++; $display("FAIL rmem_r1: got %0h exp 0", dut.regs_q[1]); end
        reset = 1'b0;
        step(2);
        checks++; if (busy !== 1'b0 || dmem_req !== 1'b0 || imem_addr !== 8'd0 || dut.regs_q[1] !== 8'd0) begin
            errors++; $display("FAIL rmem_idle_ack: busy %0d req %0d pc %0d r1 %0h exp 0 0 0 0", busy, dmem_req, imem_addr, dut.regs_q[1]); end
        dmem_ack = 1'b0;
    endtask

    task automatic test_start_ignored();
        do_reset();
        imem[0] = enc_i(LI, 2'd2, 4'd4);
        imem[1] = enc_i(LI, 2'd3, 4'd1);
        pulse_start();
        start = 1'b1;
        step(2);
        start = 1'b0;
        checks++; if (imem_addr !== 8'd1 || busy !== 1'b1) begin errors++; $display("FAIL start_ignored: pc %0d busy %0d exp 1 1", imem_addr, busy); end
        step(4);
        checks++; if (done !== 1'b1 || imem_addr !== 8'd2 || dut.regs_q[2] !== 8'd4) begin
            errors++; $display("FAIL run_halt: done %0d pc %0d r2 %0d exp 1 2 4", done, imem_addr, dut.regs_q[2]); end
        pulse_start();
        checks++; if (busy !== 1'b1 || done !== 1'b0 || imem_addr !== 8'd0 || dut.regs_q[2] !== 8'd0 || dut.regs_q[3] !== 8'd0) begin
            errors++; $display("FAIL restart: busy %0d done %0d pc %0d r2 %0d r3 %0d exp 1 0 0 0 0", busy, done, imem_addr, dut.regs_q[2], dut.regs_q[3]); end
    endtask

    initial begin
        reset = 1'b1;
        start = 1'b0;
        dmem_ack = 1'b0;
        dmem_rdata = 8'd0;
        for (int i = 0; i < 256; i++) imem[i] = {HALT, 6'd0};
        test_reset();
        test_add_prog();
        test_overflow();
        test_sub_and();
        test_mem();
        test_branch();
        test_reset_mid_mem();
        test_start_ignored();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
